// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/DIV unit with HI/LO registers.
// Results are computed at accept and held until commit.
module md_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        int_flush,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] hilo_out
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  logic        busy_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_p, lo_p;

  logic accept;
  logic is_mul, is_div, is_mthi, is_mtlo;

  assign accept  = start & ~busy_q & ~int_flush;
  assign is_mul  = (md_op == OP_MULT) | (md_op == OP_MULTU);
  assign is_div  = (md_op == OP_DIV) | (md_op == OP_DIVU);
  assign is_mthi = (md_op == OP_MTHI);
  assign is_mtlo = (md_op == OP_MTLO);

  logic [63:0] prod_s, prod_u, prod;

  assign prod_s = {{32{src_a[31]}}, src_a}
                * {{32{src_b[31]}}, src_b};
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};
  assign prod   = md_op[0] ? prod_u : prod_s;

  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag;
  logic [31:0] bs, bu;
  logic [31:0] sq, sr, uq, ur;
  logic [31:0] dq, dr;
  logic [31:0] div_hi, div_lo;

  assign a_neg  = src_a[31];
  assign b_neg  = src_b[31];
  assign b_zero = (src_b == 32'd0);
  assign a_mag  = a_neg ? (~src_a + 32'd1) : src_a;
  assign b_mag  = b_neg ? (~src_b + 32'd1) : src_b;

  // Keep the dividers X-free on a zero divisor.
  assign bs = b_zero ? 32'd1 : b_mag;
  assign bu = b_zero ? 32'd1 : src_b;

  assign sq = a_mag / bs;
  assign sr = a_mag % bs;
  assign uq = src_a / bu;
  assign ur = src_a % bu;

  always_comb begin
    dq = uq;
    dr = ur;
    if (!md_op[0]) begin
      dq = (a_neg ^ b_neg) ? (~sq + 32'd1) : sq;
      dr = a_neg ? (~sr + 32'd1) : sr;
    end
  end

  assign div_lo = b_zero ? 32'hFFFF_FFFF : dq;
  assign div_hi = b_zero ? src_a : dr;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= 4'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      hi_p   <= 32'd0;
      lo_p   <= 32'd0;
    end else if (busy_q) begin
      cnt_q <= cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_q   <= hi_p;
        lo_q   <= lo_p;
        busy_q <= 1'b0;
      end
    end else if (accept) begin
      unique case (1'b1)
        is_mul: begin
          hi_p   <= prod[63:32];
          lo_p   <= prod[31:0];
          cnt_q  <= MUL_N;
          busy_q <= 1'b1;
        end
        is_div: begin
          hi_p   <= div_hi;
          lo_p   <= div_lo;
          cnt_q  <= DIV_N;
          busy_q <= 1'b1;
        end
        is_mthi: hi_q <= src_a;
        is_mtlo: lo_q <= src_a;
        default: ;
      endcase
    end
  end

  assign busy     = busy_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign hilo_out = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vector table plus multi-cycle
// sequences for md_unit.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst, start, int_flush, rd_hi;
  logic [2:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        busy, busy1;
  logic [31:0] hi_out, lo_out, hilo_out;
  logic [31:0] hi1, lo1, hilo1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  md_unit dut (
    .clk(clk), .rst(rst), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .int_flush(int_flush),
    .rd_hi(rd_hi), .busy(busy), .hi_out(hi_out),
    .lo_out(lo_out), .hilo_out(hilo_out)
  );

  md_unit #(.MUL_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .int_flush(int_flush),
    .rd_hi(rd_hi), .busy(busy1), .hi_out(hi1),
    .lo_out(lo1), .hilo_out(hilo1)
  );

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t v[12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count sampled cycles with busy high, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] h0, l0;

    v[0]  = '{"mult_neg", 3'd0, 32'hFFFFFFFE, 32'd3,
              32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    v[1]  = '{"multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFE, 32'h00000001, 5};
    v[2]  = '{"div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    v[3]  = '{"divu_by0", 3'd3, 32'd7, 32'd0,
              32'h00000007, 32'hFFFFFFFF, 10};
    v[4]  = '{"div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF,
              32'h00000000, 32'h80000000, 10};
    v[5]  = '{"div_by0", 3'd2, 32'd5, 32'd0,
              32'h00000005, 32'hFFFFFFFF, 10};
    v[6]  = '{"div_7_m2", 3'd2, 32'd7, 32'hFFFFFFFE,
              32'h00000001, 32'hFFFFFFFD, 10};
    v[7]  = '{"divu_100_7", 3'd3, 32'd100, 32'd7,
              32'h00000002, 32'h0000000E, 10};
    v[8]  = '{"mult_big", 3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF,
              32'h3FFFFFFF, 32'h00000001, 5};
    v[9]  = '{"mthi", 3'd4, 32'h12345678, 32'd0,
              32'h12345678, 32'h00000001, 0};
    v[10] = '{"mtlo", 3'd5, 32'h9ABCDEF0, 32'd0,
              32'h12345678, 32'h9ABCDEF0, 0};
    v[11] = '{"resv6", 3'd6, 32'hDEADBEEF, 32'd1,
              32'h12345678, 32'h9ABCDEF0, 0};

    rst = 1'b1;
    start = 1'b1;
    md_op = 3'd4;
    src_a = 32'hAAAA5555;
    src_b = 32'd0;
    int_flush = 1'b0;
    rd_hi = 1'b0;
    tick();
    tick();
    start = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_idle(n);
      chk({v[i].nm, "_cyc"}, 32'(n), 32'(v[i].cyc));
      chk({v[i].nm, "_hi"}, hi_out, v[i].hi);
      chk({v[i].nm, "_lo"}, lo_out, v[i].lo);
      rd_hi = 1'b1;
      #1;
      chk({v[i].nm, "_hilo_h"}, hilo_out, v[i].hi);
      rd_hi = 1'b0;
      #1;
      chk({v[i].nm, "_hilo_l"}, hilo_out, v[i].lo);
    end

    // Start held through busy: second op waits for idle.
    start = 1'b1;
    md_op = 3'd0;
    src_a = 32'd2;
    src_b = 32'd3;
    tick();
    md_op = 3'd1;
    src_a = 32'd4;
    src_b = 32'd5;
    wait_idle(n);
    chk("held1_cyc", 32'(n), 32'd5);
    chk("held1_lo", lo_out, 32'd6);
    chk("held1_hi", hi_out, 32'd0);
    tick();
    start = 1'b0;
    chk("held2_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("held2_cyc", 32'(n), 32'd5);
    chk("held2_lo", lo_out, 32'd20);

    // Flushed starts leave state alone.
    int_flush = 1'b1;
    issue(3'd4, 32'hDEADBEEF, 32'd0);
    chk("flush_mthi_hi", hi_out, 32'd0);
    chk("flush_mthi_busy", {31'd0, busy}, 32'd0);
    issue(3'd2, 32'd9, 32'd2);
    chk("flush_div_busy", {31'd0, busy}, 32'd0);
    int_flush = 1'b0;

    // Flush mid-op does not cancel the op.
    issue(3'd2, 32'hFFFFFF9C, 32'd7);
    n = 0;
    h0 = hi_out;
    l0 = lo_out;
    while (busy === 1'b1 && n < 40) begin
      n++;
      int_flush = (n == 3);
      if (n == 5) begin
        chk("mid_hi_hold", hi_out, h0);
        chk("mid_lo_hold", lo_out, l0);
      end
      tick();
    end
    int_flush = 1'b0;
    chk("flushmid_cyc", 32'(n), 32'd10);
    chk("flushmid_lo", lo_out, 32'hFFFFFFF2);
    chk("flushmid_hi", hi_out, 32'hFFFFFFFE);

    // Reset during a divide kills it.
    issue(3'd2, 32'd50, 32'd3);
    tick();
    tick();
    tick();
    chk("rstmid_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_hi", hi_out, 32'd0);
    chk("rstmid_lo", lo_out, 32'd0);
    for (int k = 0; k < 12; k++) tick();
    chk("rstmid_late_hi", hi_out, 32'd0);
    chk("rstmid_late_lo", lo_out, 32'd0);
    chk("rstmid_late_busy", {31'd0, busy}, 32'd0);

    // Single-cycle multiply instance.
    issue(3'd0, 32'd6, 32'hFFFFFFF9);
    chk("mul1_busy", {31'd0, busy1}, 32'd1);
    chk("mul1_lo_pre", lo1, 32'd0);
    tick();
    chk("mul1_idle", {31'd0, busy1}, 32'd0);
    chk("mul1_lo", lo1, 32'hFFFFFFD6);
    chk("mul1_hi", hi1, 32'hFFFFFFFF);
    wait_idle(n);
    chk("mul5_cyc", 32'(n), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
